xbar_slave_rr_arbiter: RTL

//  Round-robin arbiter and sequencer for one TCDM/HWCE crossbar slave port.

---
 rtl/xbar_slave_rr_arbiter_if.sv | 49 ++++
 rtl/xbar_slave_rr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/xbar_slave_rr_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module      : xbar_slave_rr_arbiter_if                                     |
// | Description : Master-side and slave-side bus bundle for one crossbar port. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface xbar_slave_rr_arbiter_if #(
  parameter int NUM_INPUT  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_INPUT-1:0]              m_req_i;
  logic [NUM_INPUT*ADDR_WIDTH-1:0]   m_add_i;
  logic [NUM_INPUT-1:0]              m_wen_i;
  logic [NUM_INPUT*DATA_WIDTH-1:0]   m_wdata_i;
  logic [NUM_INPUT*DATA_WIDTH/8-1:0] m_be_i;
  logic [NUM_INPUT-1:0]              m_gnt_o;
  logic [NUM_INPUT-1:0]              m_r_valid_o;
  logic [DATA_WIDTH-1:0]             m_r_rdata_o;

  logic                              s_req_o;
  logic [ADDR_WIDTH-1:0]             s_add_o;
  logic                              s_wen_o;
  logic [DATA_WIDTH-1:0]             s_wdata_o;
  logic [DATA_WIDTH/8-1:0]           s_be_o;
  logic                              s_gnt_i;
  logic                              s_r_valid_i;
  logic [DATA_WIDTH-1:0]             s_r_rdata_i;

  // Arbiter's view of the bundle
  modport slave (
    input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
    input  s_gnt_i, s_r_valid_i, s_r_rdata_i,
    output m_gnt_o, m_r_valid_o, m_r_rdata_o,
    output s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o
  );

  // Surrounding masters and slave memory
  modport master (
    output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
    output s_gnt_i, s_r_valid_i, s_r_rdata_i,
    input  m_gnt_o, m_r_valid_o, m_r_rdata_o,
    input  s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o
  );
endinterface

`default_nettype wire

// File: rtl/xbar_slave_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : xbar_slave_rr_arbiter                                        |
// | Description : Round-robin arbiter/sequencer for one crossbar slave port,   |
// |               one outstanding transaction. Optional contention counter    |
// |               enabled by XBAR_ARB_CONTENTION_CNT_EN.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module xbar_slave_rr_arbiter #(
  parameter int                    NUM_INPUT   = 3,
  parameter int                    SEL_WIDTH   = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    LSB_ADDR    = 15,
  parameter int                    MSB_ADDR    = 17,
  parameter int                    SLAVE_NUM   = 1,
  parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET = 32'h0006_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xbar_slave_rr_arbiter_if.slave bus,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic                 busy_o
`ifdef XBAR_ARB_CONTENTION_CNT_EN
  ,
  output logic [31:0]          contention_cnt_o
`endif
);

  localparam int            FW      = MSB_ADDR - LSB_ADDR + 1;
  localparam int            BW      = DATA_WIDTH / 8;
  localparam logic [FW-1:0] C_BASE  = ADDR_OFFSET[MSB_ADDR:LSB_ADDR];
  localparam logic [FW-1:0] C_SLAVE = FW'(SLAVE_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

  logic [NUM_INPUT-1:0] w_hit;
  logic [SEL_WIDTH-1:0] w_win;
  logic [SEL_WIDTH-1:0] w_cand;
  logic [SEL_WIDTH-1:0] w_ptr_inc;
  logic                 w_any;
  int                   v_idx;

  logic [NUM_INPUT-1:0]  w_gnt;
  logic [NUM_INPUT-1:0]  w_r_valid;
  logic                  w_s_req;
  logic [ADDR_WIDTH-1:0] w_s_add;
  logic                  w_s_wen;
  logic [DATA_WIDTH-1:0] w_s_wdata;
  logic [BW-1:0]         w_s_be;

  // Field offset is taken modulo 2^FW, so windows wrap around the field range
  for (genvar k = 0; k < NUM_INPUT; k++) begin : g_decode
    logic [FW-1:0] w_field_off;
    assign w_field_off = bus.m_add_i[k*ADDR_WIDTH+LSB_ADDR +: FW] - C_BASE;
    assign w_hit[k]    = bus.m_req_i[k] && (w_field_off == C_SLAVE);
  end

  // Scan downward from the farthest candidate so the nearest hit at/after ptr wins
  always_comb begin
    w_win  = '0;
    w_any  = 1'b0;
    w_cand = '0;
    v_idx  = 0;
    for (int i = NUM_INPUT - 1; i >= 0; i--) begin
      v_idx = int'(ptr_q) + i;
      if (v_idx >= NUM_INPUT) v_idx = v_idx - NUM_INPUT;
      w_cand = v_idx[SEL_WIDTH-1:0];
      if (w_hit[w_cand]) begin
        w_win = w_cand;
        w_any = 1'b1;
      end
    end
  end

  assign w_ptr_inc = (sel_q == SEL_WIDTH'(NUM_INPUT - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    w_gnt     = '0;
    w_r_valid = '0;
    w_s_req   = 1'b0;
    w_s_add   = '0;
    w_s_wen   = 1'b0;
    w_s_wdata = '0;
    w_s_be    = '0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          sel_d   = w_win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.m_req_i[sel_q]) begin
          state_d = IDLE;
        end else begin
          w_s_req      = 1'b1;
          w_s_add      = bus.m_add_i[int'(sel_q)*ADDR_WIDTH +: ADDR_WIDTH];
          w_s_wen      = bus.m_wen_i[sel_q];
          w_s_wdata    = bus.m_wdata_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
          w_s_be       = bus.m_be_i[int'(sel_q)*BW +: BW];
          w_gnt[sel_q] = bus.s_gnt_i;
          if (bus.s_gnt_i) begin
            state_d = RESP;
            ptr_d   = w_ptr_inc;
          end
        end
      end
      RESP: begin
        w_r_valid[sel_q] = bus.s_r_valid_i;
        if (bus.s_r_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.m_gnt_o     = w_gnt;
  assign bus.m_r_valid_o = w_r_valid;
  assign bus.m_r_rdata_o = bus.s_r_rdata_i;
  assign bus.s_req_o     = w_s_req;
  assign bus.s_add_o     = w_s_add;
  assign bus.s_wen_o     = w_s_wen;
  assign bus.s_wdata_o   = w_s_wdata;
  assign bus.s_be_o      = w_s_be;
  assign sel_o           = sel_q;
  assign busy_o          = (state_q != IDLE);

`ifdef XBAR_ARB_CONTENTION_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        w_multi_hit;

  assign w_multi_hit = ($countones(w_hit) > 1);

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) && w_multi_hit && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign contention_cnt_o = cnt_q;
`else
  // Contention statistics are not built in this configuration
`endif

endmodule

`default_nettype wire
